calc_entry_ctrl: RTL and testbench

Keypad-entry and operation sequencer for the calculator. It consumes decoded button events (active_button_t) and assembles BCD operands in num_t format. It sequences an external arithmetic unit over a valid/ready request and response-pulse interface, and drives the display number. Memory, sqrt and percent keys are handled by a sibling block; this block consumes them with no effect.

---
 rtl/calc_entry_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_ctrl.sv
// Keypad entry and operation sequencer for the calculator.
// Assembles BCD operands from button events, drives the display number and
// issues one request at a time to an external arithmetic unit.

package calc_pkg;
    localparam int NumDigits = 8;

    // value = significand * 10^-exponent, BCD digits right-aligned
    typedef struct packed {
        logic                   error;
        logic                   sign;
        logic [2:0]             exponent;
        logic [NumDigits*4-1:0] significand;
    } num_t;

    typedef enum logic [4:0] {
        B_NONE = 5'd0,
        B_D0 = 5'd1, B_D1 = 5'd2, B_D2 = 5'd3, B_D3 = 5'd4, B_D4 = 5'd5,
        B_D5 = 5'd6, B_D6 = 5'd7, B_D7 = 5'd8, B_D8 = 5'd9, B_D9 = 5'd10,
        B_DOT = 5'd11,
        B_ADD = 5'd12, B_SUB = 5'd13, B_MUL = 5'd14, B_DIV = 5'd15,
        B_EQ = 5'd16, B_CLEAR = 5'd17,
        B_MC = 5'd18, B_MR = 5'd19, B_MPLUS = 5'd20, B_MMINUS = 5'd21,
        B_SQRT = 5'd22, B_PCT = 5'd23,
        B_UNKNOWN = 5'd31
    } active_button_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3, OP_DIV = 3'd4
    } op_t;

    // shift one BCD digit in at the least significant end
    function automatic num_t leftshift_significand(num_t n, logic [3:0] d);
        num_t r;
        r = n;
        r.significand = {n.significand[NumDigits*4-5:0], d};
        return r;
    endfunction
endpackage

module calc_entry_ctrl #(
    parameter int NumDigits   = 8,
    parameter int RespTimeout = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           btn_valid,
    input  logic [4:0]     btn,
    output logic           btn_ready,
    output calc_pkg::num_t disp,
    output logic           busy,
    output logic           alu_req_valid,
    input  logic           alu_req_ready,
    output calc_pkg::op_t  alu_op,
    output calc_pkg::num_t alu_a,
    output calc_pkg::num_t alu_b,
    input  logic           alu_resp_valid,
    input  calc_pkg::num_t alu_result
);
    typedef calc_pkg::num_t num_t;
    typedef calc_pkg::op_t  op_t;

    localparam int CW = $clog2(NumDigits + 1);
    localparam num_t ErrNum = {1'b1, {($bits(num_t) - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_ENTRY, S_OPWAIT, S_ISSUE, S_WAIT, S_DONE, S_ERROR
    } state_t;

    state_t          state;
    num_t            entry, acc;
    op_t             pending, next_op;
    logic            eq_issue;   // in-flight request came from '=' rather than a chained op
    logic [CW-1:0]   count;
    logic            dot;
    logic [15:0]     tmo;

    logic            xfer, is_digit, cur_ok;
    logic [3:0]      digit;
    op_t             btn_op;
    num_t            cur_next, fresh_next;

    assign xfer = btn_valid && btn_ready;

    // decode the button and precompute the entry register after a digit
    always_comb begin
        is_digit = (btn >= calc_pkg::B_D0) && (btn <= calc_pkg::B_D9);
        digit    = 4'(btn - 5'(calc_pkg::B_D0));
        // leading zeros before any dot are not counted as digits
        cur_ok   = is_digit && !(digit == 4'd0 && count == '0 && !dot)
                   && (count < CW'(NumDigits)) && (!dot || entry.exponent != 3'd7);
        cur_next = calc_pkg::leftshift_significand(entry, digit);
        if (dot) cur_next.exponent = entry.exponent + 3'd1;
        fresh_next = '0;
        fresh_next.significand = {{(calc_pkg::NumDigits*4-4){1'b0}}, digit};
        btn_op = calc_pkg::OP_NONE;
        case (btn)
            calc_pkg::B_ADD: btn_op = calc_pkg::OP_ADD;
            calc_pkg::B_SUB: btn_op = calc_pkg::OP_SUB;
            calc_pkg::B_MUL: btn_op = calc_pkg::OP_MUL;
            calc_pkg::B_DIV: btn_op = calc_pkg::OP_DIV;
            default: ;
        endcase
    end

    // sequencer: entry, operator handling, request issue and response wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ENTRY;  entry <= '0;  acc <= '0;  disp <= '0;
            alu_a <= '0;  alu_b <= '0;  alu_op <= calc_pkg::OP_NONE;
            pending <= calc_pkg::OP_NONE;  next_op <= calc_pkg::OP_NONE;
            eq_issue <= 1'b0;  alu_req_valid <= 1'b0;  btn_ready <= 1'b1;
            busy <= 1'b0;  count <= '0;  dot <= 1'b0;  tmo <= '0;
        end else begin
            case (state)
                S_ISSUE: begin
                    if (alu_req_ready) begin
                        alu_req_valid <= 1'b0;
                        state         <= S_WAIT;
                        tmo           <= '0;
                    end
                end
                S_WAIT: begin
                    // a response on the final allowed cycle still beats the timeout
                    if (alu_resp_valid) begin
                        acc <= alu_result;  disp <= alu_result;
                        btn_ready <= 1'b1;  busy <= 1'b0;
                        if (alu_result.error) begin
                            state <= S_ERROR;
                        end else if (eq_issue) begin
                            state <= S_DONE;  pending <= calc_pkg::OP_NONE;
                        end else begin
                            state <= S_OPWAIT;  pending <= next_op;
                        end
                    end else if (tmo == 16'(RespTimeout - 1)) begin
                        state <= S_ERROR;  disp <= ErrNum;
                        btn_ready <= 1'b1;  busy <= 1'b0;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end
                default: begin
                    if (xfer && btn == calc_pkg::B_CLEAR) begin
                        state <= S_ENTRY;  entry <= '0;  acc <= '0;  disp <= '0;
                        alu_a <= '0;  alu_b <= '0;  alu_op <= calc_pkg::OP_NONE;
                        pending <= calc_pkg::OP_NONE;  next_op <= calc_pkg::OP_NONE;
                        eq_issue <= 1'b0;  alu_req_valid <= 1'b0;
                        busy <= 1'b0;  count <= '0;  dot <= 1'b0;  tmo <= '0;
                    end else if (xfer && state != S_ERROR) begin
                        if (is_digit) begin
                            if (state == S_ENTRY) begin
                                if (cur_ok) begin
                                    entry <= cur_next;  disp <= cur_next;
                                    count <= count + 1'b1;
                                end
                            end else begin
                                // S_OPWAIT / S_DONE: start a new operand
                                entry <= fresh_next;  disp <= fresh_next;
                                count <= CW'(digit != 4'd0);  dot <= 1'b0;
                                state <= S_ENTRY;
                                if (state == S_DONE) pending <= calc_pkg::OP_NONE;
                            end
                        end else if (btn == calc_pkg::B_DOT) begin
                            dot <= 1'b1;
                            if (state != S_ENTRY) begin
                                entry <= '0;  disp <= '0;  count <= '0;
                                state <= S_ENTRY;
                            end
                        end else if (btn_op != calc_pkg::OP_NONE) begin
                            if (state == S_ENTRY && pending == calc_pkg::OP_NONE) begin
                                acc <= entry;  pending <= btn_op;  state <= S_OPWAIT;
                            end else if (state == S_ENTRY) begin
                                alu_a <= acc;  alu_b <= entry;  alu_op <= pending;
                                next_op <= btn_op;  eq_issue <= 1'b0;
                                alu_req_valid <= 1'b1;  state <= S_ISSUE;
                                btn_ready <= 1'b0;  busy <= 1'b1;
                            end else if (state == S_OPWAIT) begin
                                pending <= btn_op;
                            end else begin
                                acc <= disp;  pending <= btn_op;  state <= S_OPWAIT;
                            end
                        end else if (btn == calc_pkg::B_EQ) begin
                            if ((state == S_ENTRY && pending != calc_pkg::OP_NONE)
                                || state == S_OPWAIT) begin
                                alu_a <= acc;
                                alu_b <= (state == S_OPWAIT) ? acc : entry;
                                alu_op <= pending;  eq_issue <= 1'b1;
                                alu_req_valid <= 1'b1;  state <= S_ISSUE;
                                btn_ready <= 1'b0;  busy <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed scenarios plus random button/ALU traffic,
// checked every cycle against a decimal-level model of the calculator.
module tb_calc_entry_ctrl;
    import calc_pkg::*;

    localparam int T = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_valid, btn_ready, busy, alu_req_valid, alu_req_ready, alu_resp_valid;
    logic [4:0] btn;
    num_t disp, alu_a, alu_b, alu_result;
    op_t  alu_op;

    always #5 clk = ~clk;

    calc_entry_ctrl #(.NumDigits(8), .RespTimeout(T)) dut (
        .clk(clk), .rst_n(rst_n), .btn_valid(btn_valid), .btn(btn),
        .btn_ready(btn_ready), .disp(disp), .busy(busy),
        .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_resp_valid(alu_resp_valid), .alu_result(alu_result)
    );

    int checks = 0, passes = 0;
    int vcnt = 0, issues = 0;
    logic prev_v = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model (decimal value of typed digits) ----------------
    localparam int M_ENTRY = 0, M_OPW = 1, M_ISS = 2, M_WAIT = 3, M_DONE = 4, M_ERR = 5;
    int     m_st, m_cnt, m_exp, m_w;
    longint m_val;
    bit     m_dot, m_eq;
    num_t   m_disp, m_acc, m_a, m_b;
    op_t    m_pend, m_next, m_op;

    function automatic num_t mk(longint v, int e);
        num_t n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n.significand[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        n.exponent = 3'(e);
        return n;
    endfunction

    function automatic num_t lit(longint v);
        return mk(v, 0);
    endfunction

    task automatic model_reset();
        m_st = M_ENTRY; m_cnt = 0; m_exp = 0; m_w = 0; m_val = 0; m_dot = 0; m_eq = 0;
        m_disp = '0; m_acc = '0; m_a = '0; m_b = '0;
        m_pend = OP_NONE; m_next = OP_NONE; m_op = OP_NONE;
    endtask

    task automatic apply_digit(input int d);
        if (d == 0 && m_cnt == 0 && !m_dot) return;
        if (m_cnt < 8 && (!m_dot || m_exp < 7)) begin
            m_val = m_val * 10 + d;
            m_cnt++;
            if (m_dot) m_exp++;
        end
        m_disp = mk(m_val, m_exp);
    endtask

    task automatic issue(input num_t a, input num_t b, input op_t o, input bit eq);
        m_a = a; m_b = b; m_op = o; m_eq = eq; m_st = M_ISS;
    endtask

    task automatic model_button(input logic [4:0] b);
        op_t o;
        o = OP_NONE;
        if (b == B_ADD) o = OP_ADD;
        if (b == B_SUB) o = OP_SUB;
        if (b == B_MUL) o = OP_MUL;
        if (b == B_DIV) o = OP_DIV;
        if (b == B_CLEAR) begin model_reset(); return; end
        if (m_st == M_ERR) return;
        if (b >= 5'd1 && b <= 5'd10) begin
            if (m_st != M_ENTRY) begin
                if (m_st == M_DONE) m_pend = OP_NONE;
                m_val = 0; m_cnt = 0; m_exp = 0; m_dot = 0; m_disp = '0; m_st = M_ENTRY;
            end
            apply_digit(int'(b) - 1);
        end else if (b == B_DOT) begin
            if (m_st != M_ENTRY) begin
                m_val = 0; m_cnt = 0; m_exp = 0; m_disp = '0; m_st = M_ENTRY;
            end
            m_dot = 1;
        end else if (o != OP_NONE) begin
            if (m_st == M_ENTRY && m_pend == OP_NONE) begin
                m_acc = mk(m_val, m_exp); m_pend = o; m_st = M_OPW;
            end else if (m_st == M_ENTRY) begin
                issue(m_acc, mk(m_val, m_exp), m_pend, 0); m_next = o;
            end else if (m_st == M_OPW) begin
                m_pend = o;
            end else begin
                m_acc = m_disp; m_pend = o; m_st = M_OPW;
            end
        end else if (b == B_EQ) begin
            if (m_st == M_ENTRY && m_pend != OP_NONE) issue(m_acc, mk(m_val, m_exp), m_pend, 1);
            else if (m_st == M_OPW) issue(m_acc, m_acc, m_pend, 1);
        end
    endtask

    task automatic model_step(input bit bv, input logic [4:0] b, input bit rdy,
                              input bit rv, input num_t res);
        if (m_st == M_ISS) begin
            if (rdy) begin m_st = M_WAIT; m_w = 0; end
        end else if (m_st == M_WAIT) begin
            if (rv) begin
                m_acc = res; m_disp = res;
                if (res.error) m_st = M_ERR;
                else if (m_eq) begin m_st = M_DONE; m_pend = OP_NONE; end
                else begin m_st = M_OPW; m_pend = m_next; end
            end else if (m_w == T - 1) begin
                m_st = M_ERR; m_disp = '0; m_disp.error = 1'b1;
            end else m_w++;
        end else if (bv) model_button(b);
    endtask

    // the single compare point: DUT outputs against the model, every cycle
    task automatic compare();
        bit busy_exp;
        busy_exp = (m_st == M_ISS || m_st == M_WAIT);
        chk("disp", disp, m_disp);
        chk("btn_ready", btn_ready, !busy_exp);
        chk("busy", busy, busy_exp);
        chk("alu_req_valid", alu_req_valid, m_st == M_ISS);
        if (m_st == M_ISS) begin
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_op", alu_op, m_op);
        end
        if (alu_req_valid) vcnt++;
        if (alu_req_valid && !prev_v) issues++;
        prev_v = alu_req_valid;
    endtask

    // one clock: drive at negedge, advance model, compare at the next negedge
    task automatic step(input bit bv, input logic [4:0] b, input bit rdy,
                        input bit rv, input num_t res);
        btn_valid = bv; btn = b; alu_req_ready = rdy; alu_resp_valid = rv; alu_result = res;
        model_step(bv, b, rdy, rv, res);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic press(input logic [4:0] b);
        step(1'b1, b, 1'b0, 1'b0, '0);
    endtask

    task automatic pd(input int d);
        press(5'(d + 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 1'b0, '0);
    endtask

    task automatic accept();
        step(1'b0, 5'd0, 1'b1, 1'b0, '0);
    endtask

    task automatic respond(input num_t r);
        step(1'b0, 5'd0, 1'b0, 1'b1, r);
    endtask

    function automatic logic [4:0] rand_btn();
        int r;
        r = $urandom % 100;
        if (r < 45) return 5'(1 + $urandom % 10);
        if (r < 53) return B_DOT;
        if (r < 73) return 5'(12 + $urandom % 4);
        if (r < 85) return B_EQ;
        if (r < 88) return B_CLEAR;
        if ($urandom % 2 == 0) return 5'd0;
        return 5'(18 + $urandom % 14);
    endfunction

    function automatic num_t rand_num();
        num_t n;
        n = '0;
        for (int i = 0; i < 8; i++) n.significand[4*i +: 4] = 4'($urandom % 10);
        n.exponent = 3'($urandom % 8);
        n.sign = 1'($urandom % 2);
        n.error = ($urandom % 10 == 0);
        return n;
    endfunction

    initial begin
        num_t e;
        int plan;
        rst_n = 1'b0; btn_valid = 0; btn = '0; alu_req_ready = 0; alu_resp_valid = 0;
        alu_result = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_disp", disp, 64'd0);
        chk("rst_btn_ready", btn_ready, 1);
        chk("rst_valid", alu_req_valid, 0);
        chk("rst_busy", busy, 0);

        // entry encoding
        pd(0); pd(0); pd(1); pd(2); press(B_DOT); pd(5);
        e = '0; e.exponent = 3'd1; e.significand = 32'h125;
        chk("t2_disp", disp, e);
        chk("t2_model", m_disp, e);
        press(B_CLEAR);
        for (int d = 1; d <= 9; d++) pd(d);
        e = '0; e.significand = 32'h12345678;
        chk("t2_ninth", disp, e);
        chk("t2_ninth_model", m_disp, e);

        // held request
        press(B_CLEAR); pd(1); pd(2); press(B_ADD); pd(3);
        vcnt = 0;
        press(B_EQ);
        chk("t3_ready_low", btn_ready, 0);
        chk("t3_a", alu_a, lit(12));
        chk("t3_b", alu_b, lit(3));
        chk("t3_op", alu_op, OP_ADD);
        idle(3);
        accept();
        chk("t3_valid_cycles", vcnt, 4);
        idle(2);
        respond(lit(15));
        chk("t3_result", disp, lit(15));
        pd(4);
        chk("t3_after_done", disp, lit(4));

        // chained ops and operator replacement
        press(B_CLEAR); pd(2); press(B_MUL); pd(3); press(B_SUB);
        chk("t4_mul_a", alu_a, lit(2));
        chk("t4_mul_b", alu_b, lit(3));
        chk("t4_mul_op", alu_op, OP_MUL);
        accept(); respond(lit(6));
        chk("t4_disp6", disp, lit(6));
        pd(1); press(B_EQ);
        chk("t4_sub_a", alu_a, lit(6));
        chk("t4_sub_b", alu_b, lit(1));
        chk("t4_sub_op", alu_op, OP_SUB);
        accept(); respond(lit(5));
        issues = 0;
        pd(5); press(B_ADD); press(B_ADD); press(B_SUB); press(B_EQ);
        chk("t4_single_issue", issues, 1);
        chk("t4_aa_a", alu_a, lit(5));
        chk("t4_aa_b", alu_b, lit(5));
        chk("t4_aa_op", alu_op, OP_SUB);
        accept(); respond(lit(0));

        // error response
        pd(1); press(B_ADD); pd(2); press(B_EQ); accept();
        e = lit(42); e.error = 1'b1;
        respond(e);
        pd(3); press(B_ADD); press(B_EQ);
        chk("t5_err_held", disp, e);
        press(B_CLEAR);
        chk("t5_cleared", disp, 64'd0);
        pd(7);
        chk("t5_digit_again", disp, lit(7));

        // response on the last allowed cycle, then a real timeout
        press(B_ADD); press(B_EQ); accept(); idle(T - 1);
        chk("t6_busy_edge", busy, 1);
        respond(lit(14));
        chk("t6_resp_wins", disp, lit(14));
        press(B_DIV); press(B_EQ); accept(); idle(T - 1);
        chk("t6_busy_before", busy, 1);
        idle(1);
        chk("t6_timeout_disp", disp, 64'h10_0000_0000);
        chk("t6_timeout_busy", busy, 0);
        press(B_CLEAR); pd(8);
        step(1'b0, 5'd0, 1'b0, 1'b1, lit(99));
        chk("t6_stray", disp, lit(8));

        // asynchronous reset while waiting
        press(B_ADD); pd(3); press(B_EQ); accept(); idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_disp", disp, 64'd0);
        chk("t1_async_valid", alu_req_valid, 0);
        chk("t1_async_busy", busy, 0);
        chk("t1_async_ready", btn_ready, 1);
        chk("t1_async_op", alu_op, OP_NONE);
        model_reset();
        prev_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // random traffic
        plan = 0;
        for (int c = 0; c < 4000; c++) begin
            bit rdy, rv;
            rdy = (m_st == M_ISS) ? ($urandom % 3 == 0) : 1'($urandom % 2);
            if (m_st == M_ISS && rdy) begin
                int r;
                r = $urandom % 10;
                plan = (r == 0) ? T : (r == 1) ? T - 1 : int'($urandom % 4);
            end
            rv = (m_st == M_WAIT) ? (m_w == plan) : ($urandom % 8 == 0);
            step(1'($urandom % 3 != 0), rand_btn(), rdy, rv, rand_num());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
